// File: rtl/stop_watch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stop_watch_pkg
//  Purpose  : Shared types and constants for the stop-watch control path.
//  Revision : 1.0 - initial release
// ============================================================================
package stop_watch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } ctrl_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT_MAX     = 4'd9;
    localparam int   DB_CYCLES_DEF = 2_000_000;

endpackage : stop_watch_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-FF synchronizer, stability counter and one-cycle press pulse
//             on each accepted 0->1 transition of a raw push-button.
//  Revision : 1.0 - initial release
// ============================================================================
module btn_debounce
    import stop_watch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] c_cnt_last = DB_W'(DB_CYCLES - 1);

    logic            r_sync0;
    logic            r_sync1;
    logic            r_level;
    logic            r_level_q;
    logic            r_press;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0   <= btn;
            r_sync1   <= r_sync0;
            r_level_q <= r_level;
            r_press   <= r_level & ~r_level_q;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + DB_W'(1);
            end
        end
    end

    assign press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/stop_watch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stop_watch_ctrl
//  Purpose  : Button sequencer for the BCD stop-watch: debounces start/stop
//             and lap/reset, drives go/clr, holds lap time, muxes display.
//             Optional macro STOP_WATCH_CTRL_AUTOSTOP_EN freezes at 999.
//  Revision : 1.0 - initial release
// ============================================================================
module stop_watch_ctrl
    import stop_watch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       go,
    output logic       clr,
    output logic [3:0] disp2,
    output logic [3:0] disp1,
    output logic [3:0] disp0,
    output logic       run_led,
    output logic       lap_led
);

    logic        w_ss_p;
    logic        w_lr_p;
    logic        w_at_max;
    logic        w_clr_nxt;
    logic        w_capture;
    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;
    bcd_t        r_lap2;
    bcd_t        r_lap1;
    bcd_t        r_lap0;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_ss),
        .press (w_ss_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lr (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_lr),
        .press (w_lr_p)
    );

`ifdef STOP_WATCH_CTRL_AUTOSTOP_EN
    assign w_at_max = (d2 == DIGIT_MAX) && (d1 == DIGIT_MAX) && (d0 == DIGIT_MAX);
`else
    assign w_at_max = 1'b0;
`endif

    // Start/stop always outranks lap/reset when both pulses coincide.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_p) begin
                    w_state_nxt = RUN;
                end else if (w_lr_p) begin
                    w_clr_nxt = 1'b1;
                end
            end
            RUN: begin
                if (w_at_max || w_ss_p) begin
                    w_state_nxt = STOP;
                end else if (w_lr_p) begin
                    w_state_nxt = LAP;
                    w_capture   = 1'b1;
                end
            end
            LAP: begin
                if (w_at_max || w_ss_p) begin
                    w_state_nxt = STOP;
                end else if (w_lr_p) begin
                    w_state_nxt = RUN;
                end
            end
            STOP: begin
                if (w_ss_p) begin
                    if (!w_at_max) begin
                        w_state_nxt = RUN;
                    end
                end else if (w_lr_p) begin
                    w_state_nxt = IDLE;
                    w_clr_nxt   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            go      <= 1'b0;
            clr     <= 1'b0;
            r_lap2  <= '0;
            r_lap1  <= '0;
            r_lap0  <= '0;
        end else begin
            r_state <= w_state_nxt;
            go      <= (w_state_nxt == RUN) || (w_state_nxt == LAP);
            clr     <= w_clr_nxt;
            if (w_capture) begin
                r_lap2 <= d2;
                r_lap1 <= d1;
                r_lap0 <= d0;
            end
        end
    end

    assign run_led = (r_state == RUN) || (r_state == LAP);
    assign lap_led = (r_state == LAP);
    assign disp2   = lap_led ? r_lap2 : d2;
    assign disp1   = lap_led ? r_lap1 : d1;
    assign disp0   = lap_led ? r_lap0 : d0;

endmodule : stop_watch_ctrl
`default_nettype wire

// File: tb/tb_stop_watch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stop_watch_ctrl
//  Purpose  : Self-checking bench for stop_watch_ctrl with DB_CYCLES=4.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_stop_watch_ctrl;

    localparam int DB = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_STOP = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_ss;
    logic       btn_lr;
    logic [3:0] d2, d1, d0;
    logic       go, clr, run_led, lap_led;
    logic [3:0] disp2, disp1, disp0;

    stop_watch_ctrl #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .d2      (d2),
        .d1      (d1),
        .d0      (d0),
        .go      (go),
        .clr     (clr),
        .disp2   (disp2),
        .disp1   (disp1),
        .disp0   (disp0),
        .run_led (run_led),
        .lap_led (lap_led)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_seen = 0;
    int clr_go_overlap = 0;

    // Reference model: per-button stable-run counter plus a rule-based mode machine.
    int       m_mode;
    bit       m_go, m_clr;
    bit [3:0] m_lap [3];
    bit       s0 [2], s1 [2], lvl [2], rose [2], pulse [2];
    int       run_len [2];

    task automatic model_reset();
        m_mode = M_IDLE; m_go = 0; m_clr = 0;
        for (int i = 0; i < 3; i++) m_lap[i] = 4'd0;
        for (int i = 0; i < 2; i++) begin
            s0[i] = 0; s1[i] = 0; lvl[i] = 0; rose[i] = 0; pulse[i] = 0; run_len[i] = 0;
        end
    endtask

    task automatic model_step();
        bit ss, lr, at_max, raw [2];
        int nxt;
        bit nclr;
        if (rst) begin
            model_reset();
            return;
        end
        ss = pulse[0];
        lr = pulse[1];
`ifdef STOP_WATCH_CTRL_AUTOSTOP_EN
        at_max = (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
`else
        at_max = 0;
`endif
        nxt  = m_mode;
        nclr = 0;
        if (m_mode == M_IDLE) begin
            if (ss) nxt = M_RUN;
            else if (lr) nclr = 1;
        end else if (m_mode == M_RUN || m_mode == M_LAP) begin
            if (at_max || ss) nxt = M_STOP;
            else if (lr && m_mode == M_RUN) begin
                nxt = M_LAP;
                m_lap[2] = d2; m_lap[1] = d1; m_lap[0] = d0;
            end else if (lr) nxt = M_RUN;
        end else begin
            if (ss) begin
                if (!at_max) nxt = M_RUN;
            end else if (lr) begin
                nxt = M_IDLE; nclr = 1;
            end
        end
        m_mode = nxt;
        m_clr  = nclr;
        m_go   = (nxt == M_RUN) || (nxt == M_LAP);
        raw[0] = btn_ss;
        raw[1] = btn_lr;
        for (int i = 0; i < 2; i++) begin
            pulse[i] = rose[i];
            rose[i]  = 0;
            if (s1[i] != lvl[i]) begin
                run_len[i]++;
                if (run_len[i] == DB) begin
                    lvl[i]     = s1[i];
                    run_len[i] = 0;
                    rose[i]    = s1[i];
                end
            end else begin
                run_len[i] = 0;
            end
            s1[i] = s0[i];
            s0[i] = raw[i];
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [11:0] mdisp;
        @(posedge clk);
        model_step();
        #1;
        if (clr) clr_seen++;
        if (clr && go) clr_go_overlap++;
        mdisp = (m_mode == M_LAP) ? {m_lap[2], m_lap[1], m_lap[0]} : {d2, d1, d0};
        check("model", {16'd0, go, clr, run_led, lap_led, disp2, disp1, disp0},
              {16'd0, m_go, m_clr, (m_mode == M_RUN || m_mode == M_LAP), (m_mode == M_LAP), mdisp});
    endtask

    task automatic set_d(input logic [11:0] v);
        {d2, d1, d0} = v;
    endtask

    // Hold buttons for `hold` cycles, then release for 10 cycles.
    task automatic press(input bit s, input bit l, input int hold);
        btn_ss = s; btn_lr = l;
        repeat (hold) tick();
        btn_ss = 0; btn_lr = 0;
        repeat (10) tick();
    endtask

    typedef struct {
        string       name;
        bit          ss;
        bit          lr;
        int          hold;
        logic [11:0] d;
        bit          go;
        bit          run;
        bit          lap;
        logic [11:0] disp;
    } vec_t;

    vec_t tbl [$];

    task automatic add_vec(input string n, input bit s, input bit l, input int h,
                           input logic [11:0] dv, input bit g, input bit r, input bit lp,
                           input logic [11:0] dd);
        vec_t v;
        v.name = n; v.ss = s; v.lr = l; v.hold = h; v.d = dv;
        v.go = g; v.run = r; v.lap = lp; v.disp = dd;
        tbl.push_back(v);
    endtask

    int cnt_val;

    initial begin
        add_vec("idle_live",    0, 0, 3,  12'h123, 0, 0, 0, 12'h123);
        add_vec("glitch",       1, 0, 2,  12'h123, 0, 0, 0, 12'h123);
        add_vec("glitch_rel",   0, 0, 10, 12'h123, 0, 0, 0, 12'h123);
        add_vec("ss_start",     1, 0, 10, 12'h047, 1, 1, 0, 12'h047);
        add_vec("ss_hold_rel",  0, 0, 10, 12'h047, 1, 1, 0, 12'h047);
        add_vec("lap_capture",  0, 1, 10, 12'h047, 1, 1, 1, 12'h047);
        add_vec("lap_frozen",   0, 0, 10, 12'h052, 1, 1, 1, 12'h047);
        add_vec("lap_release",  0, 1, 10, 12'h052, 1, 1, 0, 12'h052);
        add_vec("lap_rel_btn",  0, 0, 10, 12'h052, 1, 1, 0, 12'h052);
        add_vec("ss_stop",      1, 0, 10, 12'h052, 0, 0, 0, 12'h052);
        add_vec("stop_rel",     0, 0, 10, 12'h052, 0, 0, 0, 12'h052);
        add_vec("lr_to_idle",   0, 1, 10, 12'h052, 0, 0, 0, 12'h052);
        add_vec("idle_rel",     0, 0, 10, 12'h052, 0, 0, 0, 12'h052);

        rst = 1; btn_ss = 0; btn_lr = 0; set_d(12'h123);
        model_reset();
        repeat (3) tick();
        check("reset_state", {28'd0, go, clr, run_led, lap_led}, 32'd0);
        rst = 0;

        foreach (tbl[i]) begin
            btn_ss = tbl[i].ss; btn_lr = tbl[i].lr; set_d(tbl[i].d);
            repeat (tbl[i].hold) tick();
            check(tbl[i].name, {16'd0, go, run_led, lap_led, 1'b0, disp2, disp1, disp0},
                  {16'd0, tbl[i].go, tbl[i].run, tbl[i].lap, 1'b0, tbl[i].disp});
        end

        // RUN -> STOP -> lr: exactly one clr pulse, never alongside go.
        press(1, 0, 10);
        press(1, 0, 10);
        check("stop_go_low", {31'd0, go}, 32'd0);
        clr_seen = 0; clr_go_overlap = 0;
        press(0, 1, 10);
        check("clr_one_pulse", clr_seen, 1);
        check("clr_not_with_go", clr_go_overlap, 0);
        check("idle_after_clr", {30'd0, run_led, go}, 32'd0);

        // Aligned ss and lr presses in RUN: ss wins.
        press(1, 0, 10);
        check("run_before_both", {31'd0, go}, 32'd1);
        clr_seen = 0;
        press(1, 1, 10);
        check("both_stop", {29'd0, go, run_led, lap_led}, 32'd0);
        check("both_no_clr", clr_seen, 0);

        // Reset in the middle of a debounce window discards the press.
        press(0, 1, 10);
        btn_ss = 1;
        repeat (4) tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (2) tick();
        btn_ss = 0;
        repeat (10) tick();
        check("rst_mid_debounce", {31'd0, go}, 32'd0);

        // Counter reaching 999 while running.
        set_d(12'h123);
        press(1, 0, 10);
        set_d(12'h999);
        tick();
`ifdef STOP_WATCH_CTRL_AUTOSTOP_EN
        check("autostop_go", {31'd0, go}, 32'd0);
        press(1, 0, 10);
        check("autostop_ss_ignored", {30'd0, go, run_led}, 32'd0);
`else
        check("autostop_go", {31'd0, go}, 32'd1);
        press(1, 0, 10);
        check("wrap_ss_stop", {30'd0, go, run_led}, 32'd0);
`endif
        clr_seen = 0;
        press(0, 1, 10);
        check("max_lr_clr", clr_seen, 1);
        check("max_lr_idle", {30'd0, go, run_led}, 32'd0);

        // Randomised run with a stepped BCD counter driven by the model's go/clr.
        cnt_val = 985;
        for (int seg = 0; seg < 120; seg++) begin
            int dur;
            dur    = $urandom_range(14, 1);
            btn_ss = ($urandom_range(2, 0) == 0);
            btn_lr = ($urandom_range(2, 0) == 0);
            for (int c = 0; c < dur; c++) begin
                rst = ($urandom_range(299, 0) == 0);
                set_d({4'(cnt_val / 100), 4'((cnt_val / 10) % 10), 4'(cnt_val % 10)});
                tick();
                if (m_clr) cnt_val = 0;
                else if (m_go) cnt_val = (cnt_val + 1) % 1000;
                if ($urandom_range(199, 0) == 0) cnt_val = 995;
            end
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stop_watch_ctrl
`default_nettype wire
